reg_file_ctx: RTL
=================

Name: reg_file_ctx

Overview:
- Parametrised successor to the core register file: 2**D registers of W bits, two combinational read ports, direct or pointer-indirect addressing through a dedicated pointer register, and a dedicated flag register.
- Adds a context save/restore engine. It streams every register out to, or in from, data memory over valid/ready handshakes.
- Sits between decode/ALU and data memory. The controller stalls the core while Busy is high.

Parameters:
- W, 8, data width; must be >= 2*D.
- D, 4, address width; depth = 2**D.
- PTR_IDX, 13, index of the pointer register. Field hi = bits [2D-1:D], field lo = bits [D-1:0].
- FLAG_IDX, 12, index of the flag register; only bit 0 is meaningful.
- BYPASS, 1, 1 = read ports forward same-cycle write data.

Ports:
- Clk, in, 1, clock; all state updates on the rising edge.
- Reset, in, 1, asynchronous active-high reset.
- RdMode, in, 1, 0 = indirect read, 1 = direct read.
- RaddrA, in, D, port A address in direct mode.
- DataOutA, out, W, read port A.
- DataOutB, out, W, read port B.
- WrMode, in, 2, 00 = none, 01 = Waddr, 10 = reg[ptr.hi], 11 = reg[ptr.lo].
- Waddr, in, D, direct write address.
- DataIn, in, W, write data.
- PtrWr, in, 1, write one pointer field from DataIn[D-1:0].
- PtrHi, in, 1, 1 = field hi, 0 = field lo.
- FlagWr, in, 1, load flag register bit 0 from FlagIn; other bits cleared.
- FlagIn, in, 1, flag value (e.g. ALU overflow).
- SaveStart, in, 1, one-cycle request to start a context save.
- RestoreStart, in, 1, one-cycle request to start a context restore.
- Busy, out, 1, engine active.
- Done, out, 1, one-cycle pulse when the engine finishes.
- SaveData, out, W, register being saved.
- SaveValid, out, 1, SaveData valid.
- SaveReady, in, 1, memory accepts SaveData.
- RestoreData, in, W, incoming register value.
- RestoreValid, in, 1, RestoreData valid.
- RestoreReady, out, 1, engine accepts RestoreData.

Behaviour:
- Reset, asynchronous and immediate, including mid-save or mid-restore:
  - all registers 0; engine returns to IDLE; index counter 0.
  - Busy, Done, SaveValid and RestoreReady are 0.
- Reads are combinational.
  - RdMode = 0: DataOutA = reg[ptr.hi], DataOutB = reg[ptr.lo].
  - RdMode = 1: DataOutA = reg[RaddrA], DataOutB = reg[PTR_IDX].
  - BYPASS = 1: if a core write in the same cycle targets the read address, the port returns the post-write value.
- Core writes take effect in IDLE only, at the clock edge.
  - WrMode indirect targets use the pointer value before the edge.
  - PtrWr to PTR_IDX overrides a WrMode write to PTR_IDX in the same cycle. The other field is preserved.
  - A WrMode write to FLAG_IDX overrides FlagWr in the same cycle.
  - FlagWr and a WrMode write to a different register both complete.
- FSM states:
  - IDLE:
    - SaveStart → SAVE; if SaveStart and RestoreStart are both high, SAVE wins.
    - else RestoreStart → REST.
    - Index counter cleared on entry to either state.
  - SAVE:
    - SaveValid = 1, SaveData = reg[idx].
    - On SaveValid & SaveReady: idx++. If idx was 2**D-1, go to FIN.
    - SaveData is held stable while SaveReady is low.
  - REST:
    - RestoreReady = 1.
    - On RestoreValid & RestoreReady: reg[idx] <= RestoreData, idx++. If idx was 2**D-1, go to FIN.
  - FIN: Done = 1 for one cycle, then IDLE.
  - Busy = 1 in SAVE, REST and FIN.
- While Busy:
  - core writes, PtrWr and FlagWr are ignored.
  - Start inputs are ignored.
  - read ports continue to operate.
- Timing and width rules:
  - idx is D+1 bits so wrap at 2**D is detectable.
  - a full transfer with no stalls takes 2**D cycles plus 1 FIN cycle.

Decomposition:
- Shared package reg_pkg holds:
  - WrMode encodings WR_NONE / WR_DIR / WR_HI / WR_LO.
  - FSM state enum IDLE / SAVE / REST / FIN.
  - Default PTR_IDX and FLAG_IDX constants.
- Natural sub-module: ctx_engine (FSM, index counter, handshake outputs). It drives the storage write port and read index into the register array.

Test Plan:
- Pointer loads: PtrWr, PtrHi=1 with DataIn=0x03, then PtrHi=0 with DataIn=0x05; then WrMode=10, DataIn=0xAA; RdMode=0 → DataOutA=0xAA, reg[13]=0x35, DataOutB=reg[5].
- Same-cycle bypass: BYPASS=1, RdMode=1, RaddrA=7, WrMode=01, Waddr=7, DataIn=0x5C → DataOutA=0x5C in that same cycle; PtrWr plus a WrMode write to 13 in one cycle → the pointer field wins.
- Stalled save: registers preloaded reg[i]=i+0x10, SaveStart, SaveReady toggling 1/0 → 16 transfers in order 0x10..0x1F, SaveData stable during stalls, a single Done pulse, Busy low afterwards.
- Restore while core writes: RestoreStart, 16 beats 0xF0..0xFF, WrMode=01 held active → reg[i]=0xF0+i and core writes are ignored.
- Reset mid-transfer: Reset asserted after 5 save beats → Busy/SaveValid drop without waiting for a clock edge; all registers are 0 after reset.
- Simultaneous starts: SaveStart and RestoreStart in the same cycle → SAVE entered, RestoreReady stays 0.

Source files
------------

// File: rtl/reg_pkg.sv
// rtl/reg_pkg.sv - shared encodings and defaults for the context-switching register file
package reg_pkg;

  typedef enum logic [1:0] {
    WR_NONE = 2'b00,
    WR_DIR  = 2'b01,
    WR_HI   = 2'b10,
    WR_LO   = 2'b11
  } wr_mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SAVE = 2'b01,
    REST = 2'b10,
    FIN  = 2'b11
  } ctx_state_e;

  localparam int PTR_IDX_DEF  = 13;
  localparam int FLAG_IDX_DEF = 12;

endpackage

// File: rtl/ctx_engine.sv
// rtl/ctx_engine.sv - save/restore sequencer: walks every register index once per transfer
module ctx_engine
  import reg_pkg::*;
#(
  parameter int D = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         save_start_i,
  input  logic         restore_start_i,
  input  logic         save_ready_i,
  input  logic         restore_valid_i,
  output logic         busy_o,
  output logic         done_o,
  output logic         save_valid_o,
  output logic         restore_ready_o,
  output logic         we_o,
  output logic [D-1:0] idx_o
);

  localparam logic [D:0] IDX_ONE = {{D{1'b0}}, 1'b1};

  ctx_state_e state_q;
  logic [D:0] idx_q;
  logic [D:0] idx_next;
  logic       busy_q;
  logic       done_q;
  logic       save_valid_q;
  logic       restore_ready_q;
  logic       save_beat;
  logic       rest_beat;

  assign save_beat = save_valid_q & save_ready_i;
  assign rest_beat = restore_ready_q & restore_valid_i;
  // The extra index bit flips exactly when the last register has been moved.
  assign idx_next  = idx_q + IDX_ONE;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q         <= IDLE;
      idx_q           <= '0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      save_valid_q    <= 1'b0;
      restore_ready_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (save_start_i) begin
            state_q      <= SAVE;
            idx_q        <= '0;
            busy_q       <= 1'b1;
            save_valid_q <= 1'b1;
          end else if (restore_start_i) begin
            state_q         <= REST;
            idx_q           <= '0;
            busy_q          <= 1'b1;
            restore_ready_q <= 1'b1;
          end
        end
        SAVE: begin
          if (save_beat) begin
            idx_q <= idx_next;
            if (idx_next[D]) begin
              state_q      <= FIN;
              save_valid_q <= 1'b0;
              done_q       <= 1'b1;
            end
          end
        end
        REST: begin
          if (rest_beat) begin
            idx_q <= idx_next;
            if (idx_next[D]) begin
              state_q         <= FIN;
              restore_ready_q <= 1'b0;
              done_q          <= 1'b1;
            end
          end
        end
        FIN: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign save_valid_o    = save_valid_q;
  assign restore_ready_o = restore_ready_q;
  assign we_o            = rest_beat;
  assign idx_o           = idx_q[D-1:0];

endmodule

// File: rtl/reg_file_ctx.sv
// rtl/reg_file_ctx.sv - register file with pointer/flag registers and context save/restore
module reg_file_ctx
  import reg_pkg::*;
#(
  parameter int W        = 8,
  parameter int D        = 4,
  parameter int PTR_IDX  = PTR_IDX_DEF,
  parameter int FLAG_IDX = FLAG_IDX_DEF,
  parameter int BYPASS   = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         rd_mode_i,
  input  logic [D-1:0] raddr_a_i,
  output logic [W-1:0] data_out_a_o,
  output logic [W-1:0] data_out_b_o,
  input  logic [1:0]   wr_mode_i,
  input  logic [D-1:0] waddr_i,
  input  logic [W-1:0] data_in_i,
  input  logic         ptr_wr_i,
  input  logic         ptr_hi_i,
  input  logic         flag_wr_i,
  input  logic         flag_in_i,
  input  logic         save_start_i,
  input  logic         restore_start_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [W-1:0] save_data_o,
  output logic         save_valid_o,
  input  logic         save_ready_i,
  input  logic [W-1:0] restore_data_i,
  input  logic         restore_valid_i,
  output logic         restore_ready_o
);

  localparam int           DEPTH    = 2**D;
  localparam logic [D-1:0] PTR_ADDR = D'(PTR_IDX);

  logic [W-1:0] regs_q [DEPTH];
  logic [W-1:0] core_d [DEPTH];
  logic [W-1:0] regs_d [DEPTH];
  logic [W-1:0] ptr_new;
  logic [D-1:0] ptr_hi;
  logic [D-1:0] ptr_lo;
  logic [D-1:0] wr_addr;
  logic [D-1:0] rd_addr_a;
  logic [D-1:0] rd_addr_b;
  logic         busy;
  logic         eng_we;
  logic [D-1:0] eng_idx;

  ctx_engine #(.D(D)) u_engine (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .save_start_i    (save_start_i),
    .restore_start_i (restore_start_i),
    .save_ready_i    (save_ready_i),
    .restore_valid_i (restore_valid_i),
    .busy_o          (busy),
    .done_o          (done_o),
    .save_valid_o    (save_valid_o),
    .restore_ready_o (restore_ready_o),
    .we_o            (eng_we),
    .idx_o           (eng_idx)
  );

  assign ptr_hi = regs_q[PTR_IDX][2*D-1:D];
  assign ptr_lo = regs_q[PTR_IDX][D-1:0];

  always_comb begin
    wr_addr = waddr_i;
    case (wr_mode_i)
      WR_HI:   wr_addr = ptr_hi;
      WR_LO:   wr_addr = ptr_lo;
      default: wr_addr = waddr_i;
    endcase
  end

  // Core-side next state; the ordering gives WrMode priority over FlagWr
  // and PtrWr priority over WrMode, with the untouched pointer field kept.
  always_comb begin
    core_d  = regs_q;
    ptr_new = regs_q[PTR_IDX];
    if (!busy) begin
      if (flag_wr_i) begin
        core_d[FLAG_IDX] = {{(W-1){1'b0}}, flag_in_i};
      end
      if (wr_mode_i != WR_NONE) begin
        core_d[wr_addr] = data_in_i;
      end
      if (ptr_wr_i) begin
        if (ptr_hi_i) begin
          ptr_new[2*D-1:D] = data_in_i[D-1:0];
        end else begin
          ptr_new[D-1:0] = data_in_i[D-1:0];
        end
        core_d[PTR_IDX] = ptr_new;
      end
    end
  end

  always_comb begin
    regs_d = core_d;
    if (eng_we) begin
      regs_d[eng_idx] = restore_data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  assign rd_addr_a = rd_mode_i ? raddr_a_i : ptr_hi;
  assign rd_addr_b = rd_mode_i ? PTR_ADDR  : ptr_lo;

  assign data_out_a_o = (BYPASS != 0) ? core_d[rd_addr_a] : regs_q[rd_addr_a];
  assign data_out_b_o = (BYPASS != 0) ? core_d[rd_addr_b] : regs_q[rd_addr_b];
  assign save_data_o  = regs_q[eng_idx];
  assign busy_o       = busy;

endmodule
